// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Desc    : Shared types and constants for the UART echo responder.
// Rev     : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_FIFO_DEPTH   = 8;
    localparam int DEFAULT_BUSY_TIMEOUT = 16;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DONE = 3'd2,
        LF_REQ    = 3'd3,
        LF_WAIT   = 3'd4
    } echo_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_echo_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_echo_responder_if
// Desc      : RX byte delivery and TX load handshake seen by the echo responder.
// Rev       : 1.0 - initial release
// ============================================================================
interface uart_echo_responder_if;

    logic [7:0] i_RX_DATA;
    logic       i_RX_DATA_READY;
    logic       i_TX_BUSY;
    logic       i_TX_DONE;
    logic [7:0] o_TX_DATA;
    logic       o_TX_DATA_READY;

    // Responder side
    modport slave (
        input  i_RX_DATA,
        input  i_RX_DATA_READY,
        input  i_TX_BUSY,
        input  i_TX_DONE,
        output o_TX_DATA,
        output o_TX_DATA_READY
    );

    // UART RX/TX side
    modport master (
        output i_RX_DATA,
        output i_RX_DATA_READY,
        output i_TX_BUSY,
        output i_TX_DONE,
        input  o_TX_DATA,
        input  o_TX_DATA_READY
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_sync_fifo
// Desc   : Synchronous FIFO; head is read combinationally, full FIFO accepts
//          a push only when a pop happens in the same cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                     i_CLK,
    input  wire logic                     i_RESET_N,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_din,
    output logic      [WIDTH-1:0]         o_dout,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    c_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module : uart_echo_responder
// Desc   : Buffers bytes from UART_RX and re-issues them to UART_TX.
//          Define UART_ECHO_CRLF_EN to append LF after every echoed CR.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  wire logic                        i_CLK,
    input  wire logic                        i_RESET_N,
    uart_echo_responder_if.slave             bus,
    input  wire logic                        i_CLEAR_OVF,
    output logic [$clog2(FIFO_DEPTH):0]      o_FIFO_COUNT,
    output logic                             o_OVERFLOW
);

    localparam int              TW        = $clog2(BUSY_TIMEOUT);
    localparam logic [TW-1:0]   c_TO_LAST = TW'(BUSY_TIMEOUT - 1);

    echo_state_t  r_state;
    logic [7:0]   r_tx_data;
    logic         r_tx_ready;
    logic [TW-1:0] r_timeout;
    logic         r_rx_ready_d;
    logic         r_overflow;

    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [7:0]   w_head;

    assign w_push = bus.i_RX_DATA_READY & ~r_rx_ready_d;
    assign w_pop  = (r_state == REQ) & bus.i_TX_BUSY;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_CLK     (i_CLK),
        .i_RESET_N (i_RESET_N),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_din     (bus.i_RX_DATA),
        .o_dout    (w_head),
        .o_count   (o_FIFO_COUNT),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // History resets high so a level already asserted at release is ignored
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_rx_ready_d <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_ready_d <= bus.i_RX_DATA_READY;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (i_CLEAR_OVF) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_tx_ready <= 1'b0;
            r_timeout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_tx_data  <= w_head;
                        r_tx_ready <= 1'b1;
                        r_timeout  <= '0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.i_TX_BUSY) begin
                        r_tx_ready <= 1'b0;
                        r_state    <= WAIT_DONE;
                    end else if (r_timeout == c_TO_LAST) begin
                        // IDLE provides the one-cycle gap before the retry
                        r_tx_ready <= 1'b0;
                        r_timeout  <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.i_TX_DONE) begin
`ifdef UART_ECHO_CRLF_EN
                        if (r_tx_data == CR) begin
                            r_tx_data  <= LF;
                            r_tx_ready <= 1'b1;
                            r_timeout  <= '0;
                            r_state    <= LF_REQ;
                        end else begin
                            r_state <= IDLE;
                        end
`else
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef UART_ECHO_CRLF_EN
                LF_REQ: begin
                    // Timeout gap is taken in place so the LF is not lost
                    if (!r_tx_ready) begin
                        r_tx_ready <= 1'b1;
                        r_timeout  <= '0;
                    end else if (bus.i_TX_BUSY) begin
                        r_tx_ready <= 1'b0;
                        r_state    <= LF_WAIT;
                    end else if (r_timeout == c_TO_LAST) begin
                        r_tx_ready <= 1'b0;
                        r_timeout  <= '0;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                LF_WAIT: begin
                    if (bus.i_TX_DONE) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_TX_DATA       = r_tx_data;
    assign bus.o_TX_DATA_READY = r_tx_ready;
    assign o_OVERFLOW          = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_echo_responder
// Desc   : Self-checking bench for uart_echo_responder (honours UART_ECHO_CRLF_EN).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_responder;

    localparam int DEPTH = 8;
    localparam int BT    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_ovf;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_echo_responder_if bus ();

    uart_echo_responder #(
        .FIFO_DEPTH   (DEPTH),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .i_CLK        (clk),
        .i_RESET_N    (rst_n),
        .bus          (bus),
        .i_CLEAR_OVF  (clear_ovf),
        .o_FIFO_COUNT (fifo_count),
        .o_OVERFLOW   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.i_RX_DATA       = b;
        bus.i_RX_DATA_READY = 1'b1;
        step();
        bus.i_RX_DATA_READY = 1'b0;
        step();
    endtask

    task automatic wait_level(input logic v, output int n);
        n = 0;
        while (bus.o_TX_DATA_READY !== v && n < 200) begin
            step();
            n++;
        end
        chk("wait_ready_level", {31'd0, bus.o_TX_DATA_READY}, {31'd0, v});
    endtask

    // Acts as UART_TX: accepts one request, then signals done
    task automatic serve(input logic [7:0] exp);
        int n;
        wait_level(1'b1, n);
        chk("tx_data", {24'd0, bus.o_TX_DATA}, {24'd0, exp});
        bus.i_TX_BUSY = 1'b1;
        step();
        bus.i_TX_BUSY = 1'b0;
        chk("ready_drop_on_busy", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        repeat (3) step();
        bus.i_TX_DONE = 1'b1;
        step();
        bus.i_TX_DONE = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int k, n, hi, lo, seen;

        rst_n               = 1'b0;
        clear_ovf           = 1'b0;
        bus.i_RX_DATA       = 8'h00;
        bus.i_RX_DATA_READY = 1'b1;
        bus.i_TX_BUSY       = 1'b0;
        bus.i_TX_DONE       = 1'b0;

        // Reset values, RX ready held high across release
        repeat (3) step();
        chk("rst_tx_data", {24'd0, bus.o_TX_DATA}, 32'd0);
        chk("rst_tx_ready", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("held_ready_count", {28'd0, fifo_count}, 32'd0);
        chk("held_ready_no_req", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        bus.i_RX_DATA_READY = 1'b0;
        step();

        // Single byte latency
        bus.i_RX_DATA       = 8'h31;
        bus.i_RX_DATA_READY = 1'b1;
        step();
        chk("single_count_n1", {28'd0, fifo_count}, 32'd1);
        chk("single_ready_n1", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        bus.i_RX_DATA_READY = 1'b0;
        step();
        chk("single_ready_n2", {31'd0, bus.o_TX_DATA_READY}, 32'd1);
        chk("single_data_n2", {24'd0, bus.o_TX_DATA}, 32'h31);
        bus.i_TX_BUSY = 1'b1;
        step();
        bus.i_TX_BUSY = 1'b0;
        chk("single_ready_m1", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        chk("single_count_m1", {28'd0, fifo_count}, 32'd0);
        repeat (2) step();
        bus.i_TX_DONE = 1'b1;
        step();
        bus.i_TX_DONE = 1'b0;

        // CR handling
        push(8'h4A); push(8'h0D); push(8'h2D);
        serve(8'h4A);
        serve(8'h0D);
`ifdef UART_ECHO_CRLF_EN
        serve(8'h0A);
`endif
        serve(8'h2D);

        // Random rounds against a byte-queue model
        for (int r = 0; r < 4; r++) begin
            exp_q.delete();
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) b = 8'h0D;
                push(b);
                exp_q.push_back(b);
`ifdef UART_ECHO_CRLF_EN
                if (b == 8'h0D) exp_q.push_back(8'h0A);
`endif
            end
            chk("rand_count", {28'd0, fifo_count}, k);
            foreach (exp_q[i]) serve(exp_q[i]);
            chk("rand_count_drained", {28'd0, fifo_count}, 32'd0);
            chk("rand_no_ovf", {31'd0, overflow}, 32'd0);
        end

        // Burst of 10 while TX stalled
        for (int i = 0; i < 10; i++) push(8'(i));
        chk("burst_count", {28'd0, fifo_count}, DEPTH);
        chk("burst_ovf", {31'd0, overflow}, 32'd1);
        wait_level(1'b0, n);
        wait_level(1'b1, n);
        wait_level(1'b0, hi);
        wait_level(1'b1, lo);
        chk("retry_high_cycles", hi, BT);
        chk("retry_gap_cycles", lo, 32'd1);
        chk("retry_same_head", {24'd0, bus.o_TX_DATA}, 32'h00);
        bus.i_RX_DATA       = 8'hEE;
        bus.i_RX_DATA_READY = 1'b1;
        clear_ovf           = 1'b1;
        step();
        bus.i_RX_DATA_READY = 1'b0;
        clear_ovf           = 1'b0;
        chk("ovf_set_beats_clear", {31'd0, overflow}, 32'd1);
        step();
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) serve(8'(i));
        chk("burst_drained", {28'd0, fifo_count}, 32'd0);

        // Push while full in the cycle busy is sampled
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        chk("full_count", {28'd0, fifo_count}, DEPTH);
        wait_level(1'b1, n);
        chk("full_head", {24'd0, bus.o_TX_DATA}, 32'h10);
        bus.i_TX_BUSY       = 1'b1;
        bus.i_RX_DATA       = 8'hAA;
        bus.i_RX_DATA_READY = 1'b1;
        step();
        bus.i_TX_BUSY       = 1'b0;
        bus.i_RX_DATA_READY = 1'b0;
        chk("pushpop_count", {28'd0, fifo_count}, DEPTH);
        chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
        chk("pushpop_ready", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        repeat (2) step();
        bus.i_TX_DONE = 1'b1;
        step();
        bus.i_TX_DONE = 1'b0;
        for (int i = 1; i < DEPTH; i++) serve(8'(8'h10 + i));
        serve(8'hAA);

        // Reset during REQ drops ready asynchronously
        push(8'h77);
        wait_level(1'b1, n);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        chk("async_rst_count", {28'd0, fifo_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Reset during WAIT_DONE with 3 buffered
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        wait_level(1'b1, n);
        bus.i_TX_BUSY = 1'b1;
        step();
        bus.i_TX_BUSY = 1'b0;
        chk("wd_count", {28'd0, fifo_count}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("wd_rst_ready", {31'd0, bus.o_TX_DATA_READY}, 32'd0);
        chk("wd_rst_count", {28'd0, fifo_count}, 32'd0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.o_TX_DATA_READY !== 1'b0 || fifo_count !== 4'd0) seen++;
        end
        chk("no_req_after_reset", seen, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_echo_responder.md
# uart_echo_responder

Byte-level responder for the far end of the UART link: it consumes bytes delivered by a UART_RX instance, buffers them in a small FIFO, and re-issues each one to a UART_TX instance through its data-ready/busy/done handshake. It sits between the RX byte interface and the TX load interface, turning the TX+RX pair into an echoing peer for link bring-up and loopback testing. Optionally it appends LF after every echoed CR.

## Interface
- FIFO_DEPTH, 8, buffered bytes; power of two, ≥2
- BUSY_TIMEOUT, 16, cycles to wait in REQ for i_TX_BUSY before retrying; ≥2
- i_CLK  in  1  system clock, rising edge
- i_RESET_N  in  1  reset, asynchronous assert, active-low
- i_RX_DATA  in  8  received byte from UART_RX, valid when i_RX_DATA_READY rises
- i_RX_DATA_READY  in  1  UART_RX data-ready level; each rising edge marks one new byte
- i_TX_BUSY  in  1  UART_TX busy; high means the byte was accepted and is shifting
- i_TX_DONE  in  1  UART_TX done pulse at end of stop bit
- i_CLEAR_OVF  in  1  clears o_OVERFLOW
- o_TX_DATA  out  8  byte presented to UART_TX
- o_TX_DATA_READY  out  1  load request to UART_TX
- o_FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered
- o_OVERFLOW  out  1  sticky; a received byte was dropped because the FIFO was full

## Operation
- Reset values: o_TX_DATA=0, o_TX_DATA_READY=0, o_FIFO_COUNT=0, o_OVERFLOW=0, FSM=IDLE, timeout counter=0. The RX-ready history register resets to 1, so a level that is already high at reset release is not taken as a byte.
- Push: a rising edge of i_RX_DATA_READY, registered against the previous-cycle value, writes i_RX_DATA into the FIFO.
- Full FIFO on push: the byte is dropped and o_OVERFLOW is set. If a pop occurs in the same cycle, the push is accepted instead.
- Overflow clear: i_CLEAR_OVF clears o_OVERFLOW. When a set and a clear occur in the same cycle, the set wins.
- Push and pop in the same cycle: both are performed and the count is unchanged.
- FSM states:
  - IDLE: when the count is >0, load the FIFO head into o_TX_DATA and go to REQ.
  - REQ: hold o_TX_DATA_READY=1 and o_TX_DATA stable.
    - When i_TX_BUSY is sampled high: pop the FIFO, drop ready, go to WAIT_DONE.
    - When the timeout counter reaches BUSY_TIMEOUT-1 without busy: drop ready for one cycle in IDLE, then retry the same head byte. The byte is not popped.
  - WAIT_DONE: ready=0. On i_TX_DONE, go to IDLE. With the CRLF feature, go to LF_REQ if the byte sent was 8'h0D.
  - LF_REQ / LF_WAIT: same rules as REQ / WAIT_DONE, with o_TX_DATA=8'h0A and no FIFO pop.
- i_TX_DONE is ignored outside WAIT_DONE and LF_WAIT. i_TX_BUSY is ignored outside REQ and LF_REQ.
- Reset mid-transfer: all state clears immediately. Buffered bytes are discarded. o_TX_DATA_READY drops asynchronously.

## Timing
- A push edge on i_RX_DATA_READY at cycle N updates o_FIFO_COUNT at N+1.
- From an empty FIFO, o_TX_DATA_READY first rises at N+2. The FIFO is written at N+1, and IDLE sees count>0 and moves to REQ.
- When busy is sampled at cycle M, ready is low and the count has decremented at M+1.
- After i_TX_DONE at cycle D, the next ready assertion is at D+2 at the earliest (IDLE, then REQ).
- Timeout retry gap: exactly one cycle with ready low.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- UART_ECHO_CRLF_EN:
  - Defined: the LF_REQ/LF_WAIT states exist, and every transmitted 8'h0D is followed by an 8'h0A transmission before the next FIFO byte.
  - Undefined: those states are not compiled, and WAIT_DONE always returns to IDLE.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, REQ, WAIT_DONE, LF_REQ, LF_WAIT)
  - ASCII constants CR=8'h0D and LF=8'h0A
  - default FIFO_DEPTH and BUSY_TIMEOUT
- One sub-module, uart_sync_fifo: a parameterised width/depth synchronous FIFO.
  - Ports: push, pop, din, dout (head, combinational from storage), count, full, empty.
  - Async active-low reset on pointers and count.
- The edge detector, FSM, timeout counter and overflow flag live in uart_echo_responder.

## Test plan
- Reset release with i_RX_DATA_READY held high -> o_FIFO_COUNT stays 0 and no TX request is issued.
- Single byte 8'h31 through a real UART_TX/UART_RX loop -> o_TX_DATA=8'h31 with one request, and the far-end RX receives 8'h31.
- Burst of 10 bytes 8'h00..8'h09 while TX is stalled (busy never asserted) with depth 8:
  - o_FIFO_COUNT reaches 8 and o_OVERFLOW=1.
  - A timeout retry is observed every BUSY_TIMEOUT+1 cycles.
  - After TX is released, bytes 8'h00..8'h07 are echoed in order.
- Push on the same cycle busy is sampled while the FIFO is full -> the byte is accepted, the count stays 8, and o_OVERFLOW is unchanged.
- With UART_ECHO_CRLF_EN, send 8'h4A, 8'h0D, 8'h2D -> TX sequence 4A, 0D, 0A, 2D. Without the macro -> 4A, 0D, 2D.
- Assert i_RESET_N low during WAIT_DONE with 3 bytes buffered -> ready drops immediately, count=0, and no further requests after release.
